// File: rtl/ppu_control_pipe.sv
// ppu_control_pipe: decodes MIPS instructions in ID into 18-bit control words
// and carries them down a DEPTH-stage registered control pipeline.
// The pipeline inserts one bubble per load-use hazard, honours global stall
// and ID flush, tracks branch delay slots, and counts issued instructions.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   id_valid, instruction    instruction presented in ID
//   stall, flush             global freeze / drop the ID instruction
//   id_ready                 ID instruction accepted this cycle (combinational)
//   ctrl_pipe, valid_pipe    per-stage control words / valids (stage 0 = EX)
//   ex_ds, illegal           stage-0 delay-slot flag / undecodable flag
//   ds_err                   one-cycle pulse: branch/jump issued in a delay slot
//   issue_count              wrapping count of issued instructions
module ppu_control_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [31:0]           instruction,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  id_ready,
  output logic [DEPTH*18-1:0]   ctrl_pipe,
  output logic [DEPTH-1:0]      valid_pipe,
  output logic                  ex_ds,
  output logic                  illegal,
  output logic                  ds_err,
  output logic [CNT_W-1:0]      issue_count
);

  localparam int unsigned CW = 18;

  typedef struct packed {
    logic [2:0] so;
    logic [3:0] alu_op;
    logic       load;
    logic       rf_en;
    logic       b;
    logic       ta;
    logic [1:0] mem_size;
    logic       mem_rw;
    logic       mem_se;
    logic       hi_en;
    logic       lo_en;
    logic       mem_en;
  } ctrl_t;

  typedef enum logic {NORM = 1'b0, DSLOT = 1'b1} ds_state_e;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs_f;
  logic [4:0] rt_f;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rs_f   = instruction[25:21];
  assign rt_f   = instruction[20:16];

  // rd/shamt/immediate bits do not influence control decode
  logic unused_imm_bits;
  assign unused_imm_bits = ^instruction[15:6];

  ctrl_t dec;
  logic  dec_illegal;

  // Instruction decode into the control word
  always_comb begin : decode
    dec         = '0;
    dec_illegal = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: dec.rf_en = 1'b1;
          6'h22, 6'h23: begin dec.rf_en = 1'b1; dec.alu_op = 4'd1;  end
          6'h24:        begin dec.rf_en = 1'b1; dec.alu_op = 4'd2;  end
          6'h25:        begin dec.rf_en = 1'b1; dec.alu_op = 4'd3;  end
          6'h26:        begin dec.rf_en = 1'b1; dec.alu_op = 4'd4;  end
          6'h27:        begin dec.rf_en = 1'b1; dec.alu_op = 4'd5;  end
          6'h2A:        begin dec.rf_en = 1'b1; dec.alu_op = 4'd6;  end
          6'h2B:        begin dec.rf_en = 1'b1; dec.alu_op = 4'd7;  end
          6'h00, 6'h04: begin dec.rf_en = 1'b1; dec.alu_op = 4'd8;  end
          6'h02, 6'h06: begin dec.rf_en = 1'b1; dec.alu_op = 4'd9;  end
          6'h03, 6'h07: begin dec.rf_en = 1'b1; dec.alu_op = 4'd10; end
          6'h10, 6'h12: dec.rf_en = 1'b1;
          6'h11:        dec.hi_en = 1'b1;
          6'h13:        dec.lo_en = 1'b1;
          6'h08:        dec.ta    = 1'b1;
          6'h09:        begin dec.ta = 1'b1; dec.rf_en = 1'b1; end
          default:      dec_illegal = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt_f)
          5'h00, 5'h01: dec.b = 1'b1;
          5'h10, 5'h11: begin dec.b = 1'b1; dec.rf_en = 1'b1; end
          default:      dec_illegal = 1'b1;
        endcase
      end
      6'h02:                      dec.ta = 1'b1;
      6'h03:                      begin dec.ta = 1'b1; dec.rf_en = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: dec.b = 1'b1;
      6'h08, 6'h09: begin dec.so = 3'b001; dec.rf_en = 1'b1; end
      6'h0A: begin dec.so = 3'b001; dec.rf_en = 1'b1; dec.alu_op = 4'd6;  end
      6'h0B: begin dec.so = 3'b001; dec.rf_en = 1'b1; dec.alu_op = 4'd7;  end
      6'h0C: begin dec.so = 3'b010; dec.rf_en = 1'b1; dec.alu_op = 4'd2;  end
      6'h0D: begin dec.so = 3'b010; dec.rf_en = 1'b1; dec.alu_op = 4'd3;  end
      6'h0E: begin dec.so = 3'b010; dec.rf_en = 1'b1; dec.alu_op = 4'd4;  end
      6'h0F: begin dec.so = 3'b011; dec.rf_en = 1'b1; dec.alu_op = 4'd11; end
      // Loads: opcode[1:0] encodes size (11 = word); LB/LH are the signed ones
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.so       = 3'b001;
        dec.load     = 1'b1;
        dec.rf_en    = 1'b1;
        dec.mem_en   = 1'b1;
        dec.mem_size = (opcode[1:0] == 2'b11) ? 2'b10 : {1'b0, opcode[0]};
        dec.mem_se   = ~opcode[2] & ~opcode[1];
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.so       = 3'b001;
        dec.mem_en   = 1'b1;
        dec.mem_rw   = 1'b1;
        dec.mem_size = (opcode[1:0] == 2'b11) ? 2'b10 : {1'b0, opcode[0]};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  ctrl_t             ctrl_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              ex_ds_q;
  logic              illegal_q;
  logic              ds_err_q;
  logic [4:0]        ex_rt_q;
  logic [CNT_W-1:0]  count_q;

  ds_state_e state_q;
  ds_state_e state_d;
  logic      in_dslot_c;
  logic      ds_err_d;

  logic hazard_c;
  logic issue_c;
  logic branch_c;

  // Load in EX whose destination feeds the ID instruction (conservative rs/rt match)
  assign hazard_c = id_valid & valid_q[0] & ctrl_q[0].load & (ex_rt_q != 5'd0) &
                    ((ex_rt_q == rs_f) | (ex_rt_q == rt_f));
  assign issue_c  = id_valid & ~reset & ~stall & ~flush & ~hazard_c;
  assign branch_c = dec.b | dec.ta;
  assign id_ready = ~reset & ~stall & (flush | ~hazard_c);

  // Delay-slot FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= NORM;
    else       state_q <= state_d;
  end

  // Delay-slot FSM: next state (bubbles leave it unchanged)
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      if (flush) begin
        state_d = NORM;
      end else if (issue_c) begin
        if (state_q == DSLOT) state_d = NORM;
        else if (branch_c)    state_d = DSLOT;
      end
    end
  end

  // Delay-slot FSM: outputs
  always_comb begin
    in_dslot_c = (state_q == DSLOT);
    ds_err_d   = issue_c & in_dslot_c & branch_c;
  end

  // Control pipeline, stage-0 side info and issue counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) ctrl_q[k] <= '0;
      valid_q   <= '0;
      ex_ds_q   <= 1'b0;
      illegal_q <= 1'b0;
      ds_err_q  <= 1'b0;
      ex_rt_q   <= 5'd0;
      count_q   <= '0;
    end else if (stall) begin
      ds_err_q <= 1'b0;
    end else begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        ctrl_q[k]  <= ctrl_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      ds_err_q <= ds_err_d;
      if (issue_c) begin
        ctrl_q[0]  <= dec;
        valid_q[0] <= 1'b1;
        ex_ds_q    <= in_dslot_c;
        illegal_q  <= dec_illegal;
        ex_rt_q    <= rt_f;
        count_q    <= count_q + CNT_W'(1);
      end else begin
        ctrl_q[0]  <= '0;
        valid_q[0] <= 1'b0;
        ex_ds_q    <= 1'b0;
        illegal_q  <= 1'b0;
        ex_rt_q    <= 5'd0;
      end
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ctrl_out
    assign ctrl_pipe[g*CW +: CW] = ctrl_q[g];
  end

  assign valid_pipe  = valid_q;
  assign ex_ds       = ex_ds_q;
  assign illegal     = illegal_q;
  assign ds_err      = ds_err_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_ppu_control_pipe.sv
// tb_ppu_control_pipe: directed scenarios plus randomized traffic, checked
// cycle by cycle against a field-by-field behavioural model of the pipe.
module tb_ppu_control_pipe;

  localparam int unsigned D  = 3;
  localparam int unsigned CW = 4;

  logic                clk;
  logic                reset;
  logic                id_valid;
  logic [31:0]         instruction;
  logic                stall;
  logic                flush;
  logic                id_ready;
  logic [D*18-1:0]     ctrl_pipe;
  logic [D-1:0]        valid_pipe;
  logic                ex_ds;
  logic                illegal;
  logic                ds_err;
  logic [CW-1:0]       issue_count;

  ppu_control_pipe #(.DEPTH(D), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .instruction (instruction),
    .stall       (stall),
    .flush       (flush),
    .id_ready    (id_ready),
    .ctrl_pipe   (ctrl_pipe),
    .valid_pipe  (valid_pipe),
    .ex_ds       (ex_ds),
    .illegal     (illegal),
    .ds_err      (ds_err),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: each control field derived from instruction-class membership
  function automatic logic [17:0] ref_decode(input logic [31:0] w, output logic ill);
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic r, r_alu, mf, mthi, mtlo, jr, jalr, regimm, bal, j, jal, bcond, imm, ld, st;
    logic [3:0] alu;
    logic [2:0] so;
    logic [1:0] sz;
    op = w[31:26]; fn = w[5:0]; rt = w[20:16];
    r      = (op == 6'h00);
    r_alu  = r && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07});
    mf     = r && (fn inside {6'h10, 6'h12});
    mthi   = r && (fn == 6'h11);
    mtlo   = r && (fn == 6'h13);
    jr     = r && (fn == 6'h08);
    jalr   = r && (fn == 6'h09);
    regimm = (op == 6'h01) && (rt inside {5'h00, 5'h01, 5'h10, 5'h11});
    bal    = (op == 6'h01) && (rt inside {5'h10, 5'h11});
    j      = (op == 6'h02);
    jal    = (op == 6'h03);
    bcond  = (op inside {6'h04, 6'h05, 6'h06, 6'h07});
    imm    = (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F});
    ld     = (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
    st     = (op inside {6'h28, 6'h29, 6'h2B});
    ill = !(r_alu || mf || mthi || mtlo || jr || jalr || regimm || j || jal || bcond || imm || ld || st);
    if (ill) return 18'h0;
    alu = 4'd0;
    if      (r && fn inside {6'h22, 6'h23})        alu = 4'd1;
    else if ((r && fn == 6'h24) || op == 6'h0C)   alu = 4'd2;
    else if ((r && fn == 6'h25) || op == 6'h0D)   alu = 4'd3;
    else if ((r && fn == 6'h26) || op == 6'h0E)   alu = 4'd4;
    else if (r && fn == 6'h27)                    alu = 4'd5;
    else if ((r && fn == 6'h2A) || op == 6'h0A)   alu = 4'd6;
    else if ((r && fn == 6'h2B) || op == 6'h0B)   alu = 4'd7;
    else if (r && fn inside {6'h00, 6'h04})        alu = 4'd8;
    else if (r && fn inside {6'h02, 6'h06})        alu = 4'd9;
    else if (r && fn inside {6'h03, 6'h07})        alu = 4'd10;
    else if (op == 6'h0F)                         alu = 4'd11;
    so = 3'b000;
    if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B} || ld || st) so = 3'b001;
    else if (op inside {6'h0C, 6'h0D, 6'h0E})              so = 3'b010;
    else if (op == 6'h0F)                                  so = 3'b011;
    sz = 2'b00;
    if (op inside {6'h21, 6'h25, 6'h29})      sz = 2'b01;
    else if (op inside {6'h23, 6'h2B})        sz = 2'b10;
    if (!(ld || st)) sz = 2'b00;
    return {so, alu, ld, (r_alu || mf || jalr || imm || ld || jal || bal),
            (bcond || regimm), (j || jal || jr || jalr), sz, st,
            (op inside {6'h20, 6'h21}), mthi, mtlo, (ld || st)};
  endfunction

  // Model state: what each stage should hold
  logic [17:0]   m_ctrl [D];
  logic [D-1:0]  m_valid;
  logic          m_ds, m_ill, m_dserr, m_in_ds;
  logic [4:0]    m_rt;
  logic [CW-1:0] m_cnt;
  logic          last_ready;

  function automatic logic m_hazard();
    return id_valid && m_valid[0] && m_ctrl[0][10] && (m_rt != 5'd0) &&
           (m_rt == instruction[25:21] || m_rt == instruction[20:16]);
  endfunction

  task automatic model_edge();
    logic [17:0] w;
    logic        il;
    if (reset) begin
      for (int k = 0; k < D; k++) m_ctrl[k] = '0;
      m_valid = '0; m_ds = 0; m_ill = 0; m_dserr = 0; m_in_ds = 0; m_rt = 0; m_cnt = '0;
    end else if (stall) begin
      m_dserr = 0;
    end else begin
      logic hz;
      hz = m_hazard();
      for (int k = D - 1; k > 0; k--) begin
        m_ctrl[k]  = m_ctrl[k-1];
        m_valid[k] = m_valid[k-1];
      end
      m_ctrl[0] = '0; m_valid[0] = 0; m_ds = 0; m_ill = 0; m_rt = 0; m_dserr = 0;
      if (flush) begin
        m_in_ds = 0;
      end else if (id_valid && !hz) begin
        w = ref_decode(instruction, il);
        m_ctrl[0]  = w;
        m_valid[0] = 1;
        m_ill      = il;
        m_rt       = instruction[20:16];
        m_ds       = m_in_ds;
        m_cnt      = m_cnt + 1'b1;
        m_dserr    = m_in_ds && (w[8] || w[7]);
        m_in_ds    = m_in_ds ? 1'b0 : (w[8] || w[7]);
      end
    end
  endtask

  // One clock: check id_ready mid-cycle, advance model at the edge, check outputs after
  task automatic step();
    logic exp_ready;
    exp_ready = !reset && !stall && (flush || !m_hazard());
    @(negedge clk);
    last_ready = id_ready;
    check("id_ready", 64'(id_ready), 64'(exp_ready));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < D; k++) check($sformatf("ctrl[%0d]", k), 64'(ctrl_pipe[k*18 +: 18]), 64'(m_ctrl[k]));
    check("valid_pipe",  64'(valid_pipe),  64'(m_valid));
    check("ex_ds",       64'(ex_ds),       64'(m_ds));
    check("illegal",     64'(illegal),     64'(m_ill));
    check("ds_err",      64'(ds_err),      64'(m_dserr));
    check("issue_count", 64'(issue_count), 64'(m_cnt));
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] ins,
                       input logic st, input logic fl);
    reset = rst; id_valid = iv; instruction = ins; stall = st; flush = fl;
    step();
  endtask

  logic [31:0] tmpl [$];

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  regimm_rt [5];
    regimm_rt[0] = 5'h00; regimm_rt[1] = 5'h01; regimm_rt[2] = 5'h10;
    regimm_rt[3] = 5'h11; regimm_rt[4] = 5'h02;
    if ($urandom_range(0, 31) == 0) return $urandom();
    w = tmpl[$urandom_range(0, tmpl.size() - 1)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    if (w[31:26] == 6'h01) w[20:16] = regimm_rt[$urandom_range(0, 4)];
    return w;
  endfunction

  localparam logic [31:0] ADDIU = 32'h24010005;
  localparam logic [31:0] LW    = 32'h8C220000;
  localparam logic [31:0] ADDU  = 32'h00421821;
  localparam logic [31:0] BEQ   = 32'h10000003;
  localparam logic [31:0] JMP   = 32'h08000000;

  initial begin
    logic [CW-1:0] held_cnt;
    logic [5:0] rfn [22] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07,
                             6'h10, 6'h12, 6'h11, 6'h13, 6'h08, 6'h09};
    logic [5:0] iop [25] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                             6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20,
                             6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h23};
    foreach (rfn[i]) tmpl.push_back({26'h0, rfn[i]});
    tmpl.push_back(32'h00000018);
    foreach (iop[i]) tmpl.push_back({iop[i], 26'h0});

    // Reset, then idle
    drive(1, 0, 0, 0, 0);
    check("reset_ready", 64'(last_ready), 64'd0);
    drive(1, 1, ADDU, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0);
    check("idle_valid", 64'(valid_pipe), 64'd0);
    check("idle_count", 64'(issue_count), 64'd0);

    // Single ADDIU walks the pipe
    drive(0, 1, ADDIU, 0, 0);
    check("addiu_s0", 64'(ctrl_pipe[17:0]), 64'h08200);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("addiu_s2", 64'(ctrl_pipe[53:36]), 64'h08200);
    check("addiu_cnt", 64'(issue_count), 64'd1);

    // Load-use: one bubble, then the consumer issues
    drive(0, 1, LW, 0, 0);
    check("lw_s0", 64'(ctrl_pipe[17:0]), 64'h08641);
    drive(0, 1, ADDU, 0, 0);
    check("lu_ready", 64'(last_ready), 64'd0);
    check("lu_bubble", 64'(valid_pipe[0]), 64'd0);
    drive(0, 1, ADDU, 0, 0);
    check("lu_issue", 64'(valid_pipe[0]), 64'd1);
    drive(0, 1, 32'h8C200000, 0, 0);
    drive(0, 1, 32'h00001821, 0, 0);
    check("lw_rt0_ready", 64'(last_ready), 64'd1);

    // Delay slot and delay-slot error
    drive(0, 1, BEQ, 0, 0);
    drive(0, 1, ADDU, 0, 0);
    check("ds_flag", 64'(ex_ds), 64'd1);
    drive(0, 1, BEQ, 0, 0);
    drive(0, 1, JMP, 0, 0);
    check("ds_err_hi", 64'(ds_err), 64'd1);
    drive(0, 1, ADDU, 0, 0);
    check("ds_err_lo", 64'(ds_err), 64'd0);
    check("ds_after_err", 64'(ex_ds), 64'd0);

    // Stall freeze, then flush with a branch in ID
    drive(0, 1, ADDIU, 0, 0);
    held_cnt = m_cnt;
    repeat (3) drive(0, 1, ADDU, 1, 0);
    check("stall_cnt", 64'(issue_count), 64'(held_cnt));
    check("stall_ready", 64'(last_ready), 64'd0);
    drive(0, 1, BEQ, 0, 1);
    check("flush_bubble", 64'(valid_pipe[0]), 64'd0);
    drive(0, 1, ADDU, 0, 0);
    check("flush_no_ds", 64'(ex_ds), 64'd0);

    // Illegal opcode still issues
    drive(0, 1, 32'hFC000000, 0, 0);
    check("ill_flag", 64'(illegal), 64'd1);
    check("ill_ctrl", 64'(ctrl_pipe[17:0]), 64'd0);
    check("ill_valid", 64'(valid_pipe[0]), 64'd1);

    // Counter wrap at 2^CW
    drive(1, 0, 0, 0, 0);
    repeat ((1 << CW) - 1) drive(0, 1, 32'h00221821, 0, 0);
    check("cnt_max", 64'(issue_count), 64'((1 << CW) - 1));
    drive(0, 1, 32'h00221821, 0, 0);
    check("cnt_wrap", 64'(issue_count), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_control_pipe.md
PPU_CONTROL_PIPE -- requirements
Module: ppu_control_pipe

Interface
REQ-001 Parameter DEPTH, default 3, number of registered control stages (EX, MEM, WB, ...); legal range 1..8.
REQ-002 Parameter CNT_W, default 16, width of the issue counter.
REQ-003 clk  input  1  the block's single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  instruction presented in ID this cycle.
REQ-006 instruction  input  32  MIPS instruction word.
REQ-007 stall  input  1  global freeze from downstream.
REQ-008 flush  input  1  discard the instruction currently in ID.
REQ-009 id_ready  output  1  ID instruction is accepted this cycle (combinational).
REQ-010 ctrl_pipe  output  DEPTH*18  stage k control word at bits [18k+17:18k]; k=0 is EX.
REQ-011 valid_pipe  output  DEPTH  per-stage valid; bubbles are 0.
REQ-012 ex_ds  output  1  stage-0 instruction occupies a branch delay slot.
REQ-013 illegal  output  1  stage-0 instruction had an undecodable opcode/funct.
REQ-014 ds_err  output  1  one-cycle pulse: branch/jump issued in a delay slot.
REQ-015 issue_count  output  CNT_W  count of instructions issued into stage 0; wraps.

Function
REQ-016 Control word fields SHALL be [17:15] SO, [14:11] ALU_OP, [10] LOAD, [9] RF_EN, [8] B, [7] TA, [6:5] MEM_SIZE, [4] MEM_RW, [3] MEM_SE, [2] HI_EN, [1] LO_EN, [0] MEM_EN; unlisted fields are 0.
REQ-017 ALU_OP: ADD/ADDU/ADDI/ADDIU/loads/stores=0000, SUB/SUBU=0001, AND/ANDI=0010, OR/ORI=0011, XOR/XORI=0100, NOR=0101, SLT/SLTI=0110, SLTU/SLTIU=0111, SLL/SLLV=1000, SRL/SRLV=1001, SRA/SRAV=1010, LUI=1011.
REQ-018 SO: 001 sign-extended imm (ADDI, ADDIU, SLTI, SLTIU, loads, stores); 010 zero-extended (ANDI, ORI, XORI); 011 LUI; 000 otherwise.
REQ-019 RF_EN=1 for R-type ALU/shift ops, MFHI, MFLO, JALR, immediate ALU ops, loads, JAL, BGEZAL, BLTZAL; MTHI sets only HI_EN; MTLO sets only LO_EN.
REQ-020 Loads: LOAD=1, MEM_EN=1, MEM_RW=0; stores: MEM_EN=1, MEM_RW=1; MEM_SIZE 00 byte, 01 half, 10 word; MEM_SE=1 only for LB, LH.
REQ-021 B=1 for BEQ, BNE, BLEZ, BGTZ and all REGIMM (op 000001) branches; TA=1 for J, JAL, JR, JALR.
REQ-022 Any other opcode/funct decodes to control word 0 with illegal=1; it still issues as valid.
REQ-023 Priority per cycle: reset > stall > flush > load-use hazard > normal issue.
REQ-024 stall=1: all stage registers, FSM, counter hold; id_ready=0; ds_err=0.
REQ-025 flush=1 (no stall): stage 0 loads a bubble (ctrl 0, valid 0, ex_ds 0, illegal 0); stages 1..DEPTH-1 shift; FSM returns to NORM; id_ready=1 (instruction consumed and dropped).
REQ-026 Hazard = id_valid & valid_pipe[0] & stage-0 LOAD & ex_rt!=0 & (ex_rt==instruction[25:21] | ex_rt==instruction[20:16]); ex_rt is the rt field captured with stage 0; comparison is conservative for all formats.
REQ-027 Hazard (no stall/flush): id_ready=0, stage 0 loads a bubble, downstream stages shift; exactly one bubble per load-use pair.
REQ-028 Normal issue (id_valid, no stall/flush/hazard): id_ready=1, stage 0 captures decoded word, valid=1, illegal, ex_ds and rt; downstream shift; issue_count increments (wraps at 2^CNT_W).
REQ-029 id_valid=0 with no stall: stage 0 loads a bubble, downstream shift, id_ready=1.
REQ-030 Latency: a word issued at edge N appears in stage k after edge N+k when no stalls intervene.
REQ-031 Delay-slot FSM states NORM, DSLOT: NORM->DSLOT on issue with B|TA; DSLOT->NORM on next issue, that instruction gets ex_ds=1; bubbles do not change state.
REQ-032 Issue with B|TA while in DSLOT: ds_err pulses for one cycle, ex_ds=1, FSM goes to NORM.

Reset
REQ-033 reset: ctrl_pipe=0, valid_pipe=0, ex_ds=0, illegal=0, ds_err=0, issue_count=0, ex_rt=0, FSM=NORM; id_ready=0 while reset is high.
REQ-034 Reset mid-flow discards all in-flight stages; the first issue after reset sees no hazard and no delay slot.

Verification
REQ-035 Reset, then idle 5 cycles -> all outputs 0, valid_pipe=0, issue_count=0.
REQ-036 ADDIU 0x24010005 issued once, DEPTH=3 -> stage 0 ctrl 18'h08200 after 1 edge, stage 2 after 3 edges, issue_count=1.
REQ-037 LW 0x8C220000 then ADDU 0x00421821 -> stage 0 ctrl 18'h08641; next cycle id_ready=0 and bubble; ADDU issues one cycle later; no hazard if LW rt=0.
REQ-038 BEQ 0x10000003 then ADDU -> ADDU has ex_ds=1; BEQ then J 0x08000000 -> ds_err=1 for one cycle, FSM back to NORM.
REQ-039 stall held 3 cycles mid-stream -> ctrl_pipe/valid_pipe/issue_count frozen; flush with BEQ in ID -> bubble, ex_ds=0 on following issue.
REQ-040 opcode 0x3F -> illegal=1, ctrl 0, valid_pipe[0]=1; issue_count wraps from 2^CNT_W-1 to 0.
